// File: rtl/npc_pkg.sv
// npc_pkg: opcode, funct and REGIMM-rt encodings plus the branch-class enum for npc_stat.
package npc_pkg;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0c;
   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;
   typedef enum logic [1:0] {NONE, UNCOND, COND} br_class_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up/down counter that saturates at 0 and all-ones, with synchronous clear.
module sat_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] cnt_q, cnt_d;
   always_comb
      cnt_d = clr ? '0 : (inc & ~&cnt_q) ? cnt_q + 1'b1 : (dec & |cnt_q) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= WIDTH'(RESET_VAL);
      else      cnt_q <= cnt_d;
   assign q = cnt_q;
endmodule

// File: rtl/npc_stat.sv
// npc_stat: next-PC selection for the single-cycle MIPS datapath with branch statistics,
// syscall halt and a bimodal branch-history table.
module npc_stat
   import npc_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned BHT_DEPTH = 16,
   parameter logic [31:0] HALT_CODE = 32'h0000000a
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [31:0]       ir,
   input  logic [ADDR_W-1:0] pc,
   input  logic [31:0]       rs_val,
   input  logic [31:0]       rt_val,
   output logic [ADDR_W-1:0] next_pc,
   output logic              taken,
   output logic              pred_taken,
   output logic              halt,
   output logic [CNT_W-1:0]  cnt_uncond,
   output logic [CNT_W-1:0]  cnt_cond,
   output logic [CNT_W-1:0]  cnt_cond_taken,
   output logic [CNT_W-1:0]  cnt_mispredict
);
   localparam int unsigned IW = $clog2(BHT_DEPTH);
   logic [5:0]        op, fn;
   logic [4:0]        rt_f;
   br_class_e         cls;
   logic              cond_true, br_taken, syscall, halt_now, halt_q, halt_d, upd, neg, zero;
   logic [ADDR_W-1:0] seq, br_tgt, j_tgt, u_tgt;
   logic [IW-1:0]     idx;
   logic [1:0]        bht [BHT_DEPTH];
   assign op   = ir[31:26];
   assign fn   = ir[5:0];
   assign rt_f = ir[20:16];
   assign neg  = rs_val[31];
   assign zero = rs_val == 32'd0;
   always_comb begin
      cls = NONE;
      if (op == OP_J || op == OP_JAL || (op == OP_SPECIAL && (fn == FN_JR || fn == FN_JALR)))
         cls = UNCOND;
      else if (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ} ||
               (op == OP_REGIMM && (rt_f == RT_BLTZ || rt_f == RT_BGEZ)))
         cls = COND;
   end
   // Default arm is REGIMM; it only matters when cls is COND.
   always_comb
      cond_true = (op == OP_BEQ)  ? rs_val == rt_val :
                  (op == OP_BNE)  ? rs_val != rt_val :
                  (op == OP_BLEZ) ? neg | zero :
                  (op == OP_BGTZ) ? ~neg & ~zero :
                  (rt_f == RT_BGEZ) ? ~neg : neg;
   assign syscall  = op == OP_SPECIAL && fn == FN_SYSCALL;
   assign halt_now = en & syscall & (rs_val == HALT_CODE);
   assign halt     = halt_q | halt_now;
   assign br_taken = (cls == COND) & cond_true;
   assign seq      = pc + ADDR_W'(4);
   assign br_tgt   = seq + {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};
   assign j_tgt    = (pc & ~ADDR_W'(32'h0fffffff)) | ADDR_W'({ir[25:0], 2'b00});
   assign u_tgt    = (op == OP_J || op == OP_JAL) ? j_tgt : ADDR_W'(rs_val);
   assign next_pc  = halt ? pc : (cls == UNCOND) ? u_tgt : br_taken ? br_tgt : seq;
   assign taken    = ~halt & ((cls == UNCOND) | br_taken);
   assign idx        = pc[2 +: IW];
   assign pred_taken = (cls == COND) & bht[idx][1];
   assign upd        = en & ~halt_q;
   assign halt_d     = halt_q | halt_now;
   always_ff @(posedge clk or negedge rst)
      if (!rst) halt_q <= 1'b0;
      else      halt_q <= halt_d;
   sat_counter #(.WIDTH(CNT_W)) u_cnt_uncond (
      .clk(clk), .rst(rst), .inc(upd & (cls == UNCOND)), .dec(1'b0), .clr(en & clr), .q(cnt_uncond));
   sat_counter #(.WIDTH(CNT_W)) u_cnt_cond (
      .clk(clk), .rst(rst), .inc(upd & (cls == COND)), .dec(1'b0), .clr(en & clr), .q(cnt_cond));
   sat_counter #(.WIDTH(CNT_W)) u_cnt_cond_taken (
      .clk(clk), .rst(rst), .inc(upd & br_taken), .dec(1'b0), .clr(en & clr), .q(cnt_cond_taken));
   sat_counter #(.WIDTH(CNT_W)) u_cnt_mispredict (
      .clk(clk), .rst(rst), .inc(upd & (cls == COND) & (pred_taken != br_taken)), .dec(1'b0),
      .clr(en & clr), .q(cnt_mispredict));
   for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
      logic hit;
      assign hit = upd & (cls == COND) & (idx == IW'(g));
      sat_counter #(.WIDTH(2), .RESET_VAL(1)) u_entry (
         .clk(clk), .rst(rst), .inc(hit & br_taken), .dec(hit & ~br_taken), .clr(1'b0), .q(bht[g]));
   end
endmodule

// File: tb/tb_npc_stat.sv
// tb_npc_stat: directed plus randomized checks of npc_stat against a behavioural model.
module tb_npc_stat;
   localparam int AW = 32, CW = 4, BD = 16;
   localparam int CMAX = (1 << CW) - 1;
   logic          clk = 1'b0, rst = 1'b0, en = 1'b0, clr = 1'b0;
   logic [31:0]   ir = '0, rs_val = '0, rt_val = '0;
   logic [AW-1:0] pc = '0;
   logic [AW-1:0] next_pc;
   logic          taken, pred_taken, halt;
   logic [CW-1:0] cnt_uncond, cnt_cond, cnt_cond_taken, cnt_mispredict;
   int checks = 0, errors = 0;
   int m_cnt [4];
   int m_bht [BD];
   bit m_halt;
   logic [31:0] e_npc;
   bit e_tk, e_pt, e_halt, e_unc, e_cnd;

   npc_stat #(.ADDR_W(AW), .CNT_W(CW), .BHT_DEPTH(BD)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .ir(ir), .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
      .next_pc(next_pc), .taken(taken), .pred_taken(pred_taken), .halt(halt),
      .cnt_uncond(cnt_uncond), .cnt_cond(cnt_cond), .cnt_cond_taken(cnt_cond_taken),
      .cnt_mispredict(cnt_mispredict));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int op, input int rt, input int imm);
      return {6'(op), 5'd1, 5'(rt), 16'(imm)};
   endfunction
   function automatic logic [31:0] enc_j(input int op, input int idx);
      return {6'(op), 26'(idx)};
   endfunction
   function automatic logic [31:0] enc_r(input int fn);
      return {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'(fn)};
   endfunction
   function automatic int sat(input int v);
      return v > CMAX ? CMAX : v;
   endfunction

   task automatic model_reset();
      m_cnt = '{0, 0, 0, 0};
      foreach (m_bht[i]) m_bht[i] = 1;
      m_halt = 0;
   endtask

   task automatic model_comb();
      int op, fn, rtf, idx;
      bit ct;
      logic [31:0] seq;
      op  = int'(ir[31:26]);
      fn  = int'(ir[5:0]);
      rtf = int'(ir[20:16]);
      e_unc = op == 2 || op == 3 || (op == 0 && (fn == 8 || fn == 9));
      e_cnd = (op >= 4 && op <= 7) || (op == 1 && rtf <= 1);
      case (op)
         4: ct = rs_val == rt_val;
         5: ct = rs_val != rt_val;
         6: ct = $signed(rs_val) <= 0;
         7: ct = $signed(rs_val) > 0;
         1: ct = (rtf == 0) ? $signed(rs_val) < 0 : $signed(rs_val) >= 0;
         default: ct = 0;
      endcase
      e_halt = m_halt || (en && op == 0 && fn == 12 && rs_val == 32'd10);
      seq = pc + 32'd4;
      if (e_halt) e_npc = pc;
      else if (e_unc) e_npc = (op == 2 || op == 3) ? ((pc & 32'hF0000000) | (ir & 32'h03FFFFFF) * 4) : rs_val;
      else if (e_cnd && ct) e_npc = seq + 32'(int'($signed(ir[15:0])) * 4);
      else e_npc = seq;
      e_tk = !e_halt && (e_unc || (e_cnd && ct));
      idx  = int'(pc / 4) % BD;
      e_pt = e_cnd && m_bht[idx] >= 2;
   endtask

   task automatic model_edge();
      int idx;
      idx = int'(pc / 4) % BD;
      if (en && clr) m_cnt = '{0, 0, 0, 0};
      else if (en && !m_halt) begin
         m_cnt[0] = sat(m_cnt[0] + int'(e_unc));
         m_cnt[1] = sat(m_cnt[1] + int'(e_cnd));
         m_cnt[2] = sat(m_cnt[2] + int'(e_cnd && e_tk));
         m_cnt[3] = sat(m_cnt[3] + int'(e_cnd && (e_pt != e_tk)));
      end
      if (en && !m_halt && e_cnd)
         m_bht[idx] = e_tk ? (m_bht[idx] == 3 ? 3 : m_bht[idx] + 1) : (m_bht[idx] == 0 ? 0 : m_bht[idx] - 1);
      m_halt = e_halt;
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_cnt_uncond"}, 64'(cnt_uncond), 64'(m_cnt[0]));
      check({tag, "_cnt_cond"}, 64'(cnt_cond), 64'(m_cnt[1]));
      check({tag, "_cnt_cond_taken"}, 64'(cnt_cond_taken), 64'(m_cnt[2]));
      check({tag, "_cnt_mispredict"}, 64'(cnt_mispredict), 64'(m_cnt[3]));
   endtask

   task automatic step(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input bit e = 1, input bit c = 0);
      ir = i; pc = p; rs_val = a; rt_val = b; en = e; clr = c;
      #1;
      model_comb();
      check({tag, "_next_pc"}, 64'(next_pc), 64'(e_npc));
      check({tag, "_taken"}, 64'(taken), 64'(e_tk));
      check({tag, "_pred_taken"}, 64'(pred_taken), 64'(e_pt));
      check({tag, "_halt"}, 64'(halt), 64'(e_halt));
      check_cnts(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      model_reset();
      model_comb();
      check_cnts(tag);
      check({tag, "_halt"}, 64'(halt), 64'(e_halt));
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'd10;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ri, rp, ra, rb;
      model_reset();
      #1;
      check_cnts("reset");
      @(negedge clk);
      rst = 1'b1;
      step("seq", enc_r(32), 32'h00400000, 0, 0);
      check("seq_npc_const", 64'(e_npc), 64'h00400004);
      for (int k = 0; k < 3; k++) step("beq", enc_i(4, 0, 16'hFFFF), 32'h00400010, 5, 5);
      check("beq_cond", 64'(cnt_cond), 64'd3);
      check("beq_cond_taken", 64'(cnt_cond_taken), 64'd3);
      check("beq_mispredict", 64'(cnt_mispredict), 64'd1);
      step("bltz", enc_i(1, 0, 16'h0010), 32'h00400020, 32'h80000000, 0);
      step("bgtz", enc_i(7, 0, 16'h0010), 32'h00400024, 32'h80000000, 0);
      step("jalr", enc_r(9), 32'h00400028, 32'h00400100, 0);
      step("j", enc_j(2, 32'h40), 32'h10000000, 0, 0);
      check("jumps_uncond", 64'(cnt_uncond), 64'd2);
      step("halt", enc_r(12), 32'h00400030, 32'd10, 0);
      for (int k = 0; k < 2; k++) step("halted_beq", enc_i(4, 0, 16'h0004), 32'h00400034, 1, 1);
      check("halted_cond", 64'(cnt_cond), 64'd5);
      async_reset("rst1");
      step("sys9", enc_r(12), 32'h00400040, 32'd9, 0);
      check("sys9_halt", 64'(halt), 64'd0);
      for (int k = 0; k < 20; k++) step("jsat", enc_j(2, k), 32'h00400000, 0, 0);
      check("sat_uncond", 64'(cnt_uncond), 64'(CMAX));
      step("jclr", enc_j(2, 5), 32'h00400000, 0, 0, 1, 1);
      check("clr_uncond", 64'(cnt_uncond), 64'd0);
      for (int n = 0; n < 800; n++) begin
         case ($urandom_range(0, 11))
            0:  ri = enc_j(2, $urandom);
            1:  ri = enc_j(3, $urandom);
            2:  ri = enc_i(4, $urandom_range(0, 31), $urandom);
            3:  ri = enc_i(5, $urandom_range(0, 31), $urandom);
            4:  ri = enc_i(6, 0, $urandom);
            5:  ri = enc_i(7, 0, $urandom);
            6:  ri = enc_i(1, $urandom_range(0, 3), $urandom);
            7:  ri = enc_r(8);
            8:  ri = enc_r(9);
            9:  ri = enc_r(12);
            10: ri = enc_r(32);
            default: ri = $urandom;
         endcase
         rp = ($urandom_range(0, 7) == 0) ? $urandom : 32'h00400000 + 32'($urandom_range(0, 31)) * 4;
         ra = pick_val();
         rb = $urandom_range(0, 1) ? ra : pick_val();
         step("rnd", ri, rp, ra, rb, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0 || (m_halt && $urandom_range(0, 9) == 0)) async_reset("rnd_rst");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
